mem_arbiter: RTL
================

# mem_arbiter

Shares one single-port synchronous memory between the CPU's instruction-fetch path and its load/store path. Each requester uses a level req / one-cycle ack handshake. The arbiter serializes transactions, picks round-robin on contention, and drives the memory with registered enable, address and data. It sits between `program_counter`/decoder-controlled data accesses and the unified memory when the design moves off separate instruction and data memories.

## Interface
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- LATENCY, 1, memory read latency in cycles (legal 1..15): mem_rdata is valid LATENCY cycles after the cycle mem_en is high.

- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- i_req  in  1  instruction fetch request (read only); held until i_ack.
- i_addr  in  ADDR_W  fetch address; stable while i_req is high.
- i_ack  out  1  one-cycle pulse; i_rdata valid in the same cycle.
- i_rdata  out  DATA_W  fetched word; held until the next i_ack.
- d_req  in  1  data request; held until d_ack.
- d_we  in  1  1 = write, 0 = read; stable while d_req is high.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  write data.
- d_ack  out  1  one-cycle pulse; for reads, d_rdata is valid in the same cycle.
- d_rdata  out  DATA_W  load data; held until the next read d_ack.
- mem_en  out  1  memory access strobe, one cycle per transaction.
- mem_we  out  1  memory write enable; qualified by mem_en.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data.
- busy  out  1  high in every state except IDLE.

## Operation
- States: IDLE, ISSUE, WAIT, ACK.
- **IDLE:** samples i_req and d_req.
  - Only one is high: grant it.
  - Both are high: grant the port that is not last_grant (round-robin).
  - Neither is high: stay in IDLE.
  - On grant: latch the port, address, we and wdata into the mem_* registers, update last_grant, and go to ISSUE.
  - last_grant resets to IFETCH, so the first tie goes to the data port.
- **ISSUE:** mem_en is 1 for exactly this cycle, and mem_we = latched we.
  - Write: go to ACK.
  - Read: load cnt = LATENCY-1 and go to WAIT.
- **WAIT:** when cnt == 0, capture mem_rdata into the granted port's rdata register and go to ACK; otherwise decrement cnt.
  - cnt is a 4-bit counter.
  - With LATENCY=1, WAIT lasts exactly one cycle.
- **ACK:** the granted port's ack is 1 for this cycle only. No new grant is made in ACK, so a requester's still-high req in the ack cycle is never double-granted. Next state is IDLE.
- mem_addr, mem_wdata and mem_we hold their last values outside ISSUE. The memory must qualify them with mem_en.
- The ifetch port never writes: the write path is reachable only from the data port.
- req dropped before ack is a protocol violation. The transaction still completes and ack still pulses.
- The port that is not granted sees no ack and its rdata is unchanged.
- **Reset (asynchronous, any state):**
  - State goes to IDLE, cnt to 0, last_grant to IFETCH.
  - All outputs (i_ack, d_ack, i_rdata, d_rdata, mem_en, mem_we, mem_addr, mem_wdata, busy) go to 0.
  - Any in-flight transaction is abandoned with no ack.

## Timing
- Let T be the cycle in which the arbiter samples req high in IDLE.
- Read: mem_en is high in T+1, mem_rdata is sampled in T+1+LATENCY, and ack is high in T+2+LATENCY. LATENCY=1 gives ack at T+3.
- Write: mem_en and mem_we are high in T+1, and ack is high in T+2.
- After ack, the earliest next grant is sampled in the cycle after ACK.
  - Back-to-back reads from one port: one ack every LATENCY+3 cycles.
  - Back-to-back writes: one ack every 3 cycles.
- All outputs are registered. No combinational path from any input to any output.

## Test plan
- **Reset values:** assert rst mid-cycle with no clock edge -> all outputs 0 immediately. Release it with no requests -> busy=0 and mem_en never pulses.
- **Single fetch, LATENCY=1:** i_req=1, i_addr=0x40 sampled at T; memory returns 0x12345678 -> mem_en=1, mem_we=0, mem_addr=0x40 at T+1; i_ack=1 with i_rdata=0x12345678 at T+3; d_ack stays 0.
- **Data write:** d_req=1, d_we=1, d_addr=0x100, d_wdata=0xDEADBEEF at T -> mem_en=mem_we=1 with that address and data at T+1; d_ack=1 at T+2; d_rdata unchanged.
- **Contention after reset:** both req high and held -> grants alternate data, ifetch, data, ifetch. With LATENCY=3, acks land 6 cycles apart and no port is starved.
- **LATENCY=4 read with i_req held through ack:** ack occurs exactly at T+6. The held i_req is not regranted in the ACK cycle; the next grant is sampled at T+7 and mem_en is next high at T+8.
- **Reset mid-WAIT:** assert rst during WAIT -> no ack ever issued for that transaction. After release, a new d_req is served normally.

Source files
------------

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous memory
// between the instruction-fetch port and the load/store port.
module mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ack,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              last_q, last_d;
    logic              gnt_q, gnt_d;
    logic              i_ack_q, i_ack_d;
    logic              d_ack_q, d_ack_d;
    logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              busy_q, busy_d;
    logic              pick_d;

    // last/gnt encoding: 0 = ifetch, 1 = data; a tie goes to the other port
    assign pick_d = (i_req && d_req) ? ~last_q : d_req;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        last_d      = last_q;
        gnt_d       = gnt_q;
        i_ack_d     = 1'b0;
        d_ack_d     = 1'b0;
        i_rdata_d   = i_rdata_q;
        d_rdata_d   = d_rdata_q;
        mem_en_d    = 1'b0;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        unique case (state_q)
            IDLE: begin
                if (i_req || d_req) begin
                    state_d    = ISSUE;
                    gnt_d      = pick_d;
                    last_d     = pick_d;
                    mem_en_d   = 1'b1;
                    mem_we_d   = pick_d & d_we;
                    mem_addr_d = pick_d ? d_addr : i_addr;
                    if (pick_d) mem_wdata_d = d_wdata;
                end
            end
            ISSUE: begin
                if (mem_we_q) begin
                    state_d = ACK;
                    d_ack_d = gnt_q;
                    i_ack_d = ~gnt_q;
                end else begin
                    state_d = WAIT;
                    cnt_d   = CNT_INIT;
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = ACK;
                    if (gnt_q) begin
                        d_rdata_d = mem_rdata;
                        d_ack_d   = 1'b1;
                    end else begin
                        i_rdata_d = mem_rdata;
                        i_ack_d   = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ACK: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            last_q      <= 1'b0;
            gnt_q       <= 1'b0;
            i_ack_q     <= 1'b0;
            d_ack_q     <= 1'b0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            last_q      <= last_d;
            gnt_q       <= gnt_d;
            i_ack_q     <= i_ack_d;
            d_ack_q     <= d_ack_d;
            i_rdata_q   <= i_rdata_d;
            d_rdata_q   <= d_rdata_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            busy_q      <= busy_d;
        end
    end

    assign i_ack     = i_ack_q;
    assign d_ack     = d_ack_q;
    assign i_rdata   = i_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = busy_q;

endmodule
